// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Imported by the top level and by the read-port slice.
package rf_pkg;

   localparam int RF_WIDTH = 8;
   localparam int RF_DEPTH = 8;

   // Smallest w such that 2**w >= n; DEPTH is a power of two so this is exact.
   function automatic int rf_clog2(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array select, writeback bypass,
// register-0 zeroing and the pending-source hazard flag.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int WIDTH   = RF_WIDTH,
   parameter int DEPTH   = RF_DEPTH,
   parameter int AW      = rf_clog2(RF_DEPTH),
   parameter int R0_ZERO = 0
) (
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] regs [DEPTH],
   input  logic [DEPTH-1:0] pend,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] val,
   output logic             busy
);

   logic hit;
   logic is_r0;

   // NOTE: every output of an always_comb gets a value on entry, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      hit   = wr_en && (wr_addr == addr);
      is_r0 = (R0_ZERO != 0) && (addr == '0);
      val   = regs[addr];
      busy  = pend[addr];
      if (hit) begin
         val  = wr_data;
         busy = 1'b0;
      end
      // Hard-wired zero beats the bypass: writes to r0 never land anyway.
      if (is_r0) begin
         val  = '0;
         busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Flop-based register file with a per-register pending scoreboard,
// same-cycle writeback bypass and an equality / unsigned-less-than comparator.
module regfile_sb
   import rf_pkg::*;
#(
   parameter  int WIDTH   = RF_WIDTH,
   parameter  int DEPTH   = RF_DEPTH,
   parameter  int R0_ZERO = 0,
   localparam int AW      = rf_clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [AW-1:0]    rd_addr1,
   input  logic [AW-1:0]    rd_addr2,
   output logic [WIDTH-1:0] rd_val1,
   output logic [WIDTH-1:0] rd_val2,
   output logic             cmp_eq,
   output logic             cmp_lt,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_addr,
   output logic             busy1,
   output logic             busy2,
   output logic             stall,
   output logic             rsv_err
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pend;
   logic [DEPTH-1:0] pend_nxt;
   logic             wr_ok;
   logic             rsv_ok;
   logic             err_hit;

   // Writes and reservations aimed at a hard-wired r0 are dropped here.
   always_comb begin
      wr_ok    = wr_en  && !((R0_ZERO != 0) && (wr_addr  == '0));
      rsv_ok   = rsv_en && !((R0_ZERO != 0) && (rsv_addr == '0));
      err_hit  = rsv_ok && pend[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));
      pend_nxt = pend;
      if (wr_ok)  pend_nxt[wr_addr]  = 1'b0;
      // A new producer supersedes a same-cycle writeback, so set comes last.
      if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   // NOTE: the storage array is reset element by element; this is only
   // affordable because it is built from flops rather than a RAM macro.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pend    <= '0;
         rsv_err <= 1'b0;
      end else begin
         if (wr_ok) regs[wr_addr] <= wr_data;
         pend <= pend_nxt;
         if (err_hit) rsv_err <= 1'b1;
      end
   end

   rf_read_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .R0_ZERO(R0_ZERO)
   ) u_port1 (
      .addr   (rd_addr1),
      .regs   (regs),
      .pend   (pend),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .val    (rd_val1),
      .busy   (busy1)
   );

   rf_read_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .R0_ZERO(R0_ZERO)
   ) u_port2 (
      .addr   (rd_addr2),
      .regs   (regs),
      .pend   (pend),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .val    (rd_val2),
      .busy   (busy2)
   );

   always_comb begin
      cmp_eq = (rd_val1 == rd_val2);
      cmp_lt = (rd_val1 <  rd_val2);
      stall  = busy1 | busy2;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with a writable r0 and one
// with a hard-wired r0, both driven by the same stimulus.
module tb_regfile_sb;

   logic       CLK = 1'b0;
   logic       RSTn;
   logic [2:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
   logic [7:0] wr_data;
   logic       wr_en, rsv_en;

   logic [7:0] a_val1, a_val2, z_val1, z_val2;
   logic       a_eq, a_lt, a_busy1, a_busy2, a_stall, a_err;
   logic       z_eq, z_lt, z_busy1, z_busy2, z_stall, z_err;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   regfile_sb #(.WIDTH(8), .DEPTH(8), .R0_ZERO(0)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_val1(a_val1), .rd_val2(a_val2),
      .cmp_eq(a_eq), .cmp_lt(a_lt),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy1(a_busy1), .busy2(a_busy2), .stall(a_stall), .rsv_err(a_err)
   );

   regfile_sb #(.WIDTH(8), .DEPTH(8), .R0_ZERO(1)) dut_z (
      .CLK(CLK), .RSTn(RSTn),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_val1(z_val1), .rd_val2(z_val2),
      .cmp_eq(z_eq), .cmp_lt(z_lt),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy1(z_busy1), .busy2(z_busy2), .stall(z_stall), .rsv_err(z_err)
   );

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later,
   // well clear of the next rising edge that commits the step.
   task automatic step(input logic rst_n, input logic we, input logic [2:0] wa,
                       input logic [7:0] wd, input logic re, input logic [2:0] ra,
                       input logic [2:0] a1, input logic [2:0] a2);
      @(negedge CLK);
      RSTn = rst_n; wr_en = we; wr_addr = wa; wr_data = wd;
      rsv_en = re; rsv_addr = ra; rd_addr1 = a1; rd_addr2 = a2;
      #1;
   endtask

   initial begin
      RSTn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0; rd_addr1 = '0; rd_addr2 = '0;

      // Reset with a write and a reservation that must both be ignored.
      step(0, 1, 3'd3, 8'hAA, 1, 3'd5, 3'd3, 3'd5);
      step(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd5);
      chk8("rst_val1", a_val1, 8'h00);
      chk1("rst_stall_in", a_stall, 1'b0);

      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd5);
      chk8("post_rst_r3", a_val1, 8'h00);
      chk8("post_rst_r5", a_val2, 8'h00);
      chk1("post_rst_eq", a_eq, 1'b1);
      chk1("post_rst_lt", a_lt, 1'b0);
      chk1("post_rst_stall", a_stall, 1'b0);
      chk1("post_rst_err", a_err, 1'b0);

      // Write r2 with same-cycle bypass, then read back from the array.
      step(1, 1, 3'd2, 8'h5A, 0, 3'd0, 3'd2, 3'd5);
      chk8("bypass_r2", a_val1, 8'h5A);
      chk1("bypass_eq", a_eq, 1'b0);
      chk1("bypass_lt", a_lt, 1'b0);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd5);
      chk8("stored_r2", a_val1, 8'h5A);

      // Comparator on stored values in both port orders.
      step(1, 1, 3'd1, 8'h10, 0, 3'd0, 3'd0, 3'd0);
      step(1, 1, 3'd4, 8'h20, 0, 3'd0, 3'd0, 3'd0);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 3'd4);
      chk8("cmp_r1", a_val1, 8'h10);
      chk8("cmp_r4", a_val2, 8'h20);
      chk1("cmp_eq_14", a_eq, 1'b0);
      chk1("cmp_lt_14", a_lt, 1'b1);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd4, 3'd1);
      chk1("cmp_eq_41", a_eq, 1'b0);
      chk1("cmp_lt_41", a_lt, 1'b0);

      // Reserve r6; busy appears only after the edge.
      step(1, 0, 3'd0, 8'h00, 1, 3'd6, 3'd6, 3'd2);
      chk1("rsv_cycle_busy1", a_busy1, 1'b0);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd6, 3'd6);
      chk1("pend_busy1", a_busy1, 1'b1);
      chk1("pend_busy2", a_busy2, 1'b1);
      chk1("pend_stall", a_stall, 1'b1);
      step(1, 1, 3'd6, 8'h77, 0, 3'd0, 3'd6, 3'd6);
      chk1("wb_busy1", a_busy1, 1'b0);
      chk1("wb_stall", a_stall, 1'b0);
      chk8("wb_val1", a_val1, 8'h77);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd6, 3'd2);
      chk1("cleared_busy1", a_busy1, 1'b0);
      chk8("cleared_val1", a_val1, 8'h77);

      // Reserve and write the same register: set wins, data still lands.
      step(1, 1, 3'd6, 8'h33, 1, 3'd6, 3'd2, 3'd2);
      step(1, 0, 3'd0, 8'h00, 1, 3'd6, 3'd6, 3'd2);
      chk1("setwins_busy1", a_busy1, 1'b1);
      chk8("setwins_val1", a_val1, 8'h33);
      chk1("setwins_err", a_err, 1'b0);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd6, 3'd2);
      chk1("double_rsv_err", a_err, 1'b1);
      step(1, 1, 3'd6, 8'h44, 0, 3'd0, 3'd2, 3'd2);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd6, 3'd2);
      chk1("sticky_err", a_err, 1'b1);
      chk1("sticky_busy1", a_busy1, 1'b0);

      // Reset while r7 is pending drops the reservation and the error.
      step(1, 0, 3'd0, 8'h00, 1, 3'd7, 3'd7, 3'd6);
      step(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd7, 3'd6);
      chk1("held_err_in_rst", a_err, 1'b1);
      step(1, 1, 3'd7, 8'h12, 0, 3'd0, 3'd6, 3'd6);
      chk1("rst2_err", a_err, 1'b0);
      chk8("rst2_r6", a_val1, 8'h00);
      chk1("rst2_eq", a_eq, 1'b1);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd7, 3'd6);
      chk8("late_wb_r7", a_val1, 8'h12);
      chk1("late_wb_busy1", a_busy1, 1'b0);
      chk1("late_wb_err", a_err, 1'b0);

      // Register 0: writable on dut, hard-wired zero on dut_z.
      step(1, 1, 3'd0, 8'hFF, 1, 3'd0, 3'd0, 3'd0);
      chk8("r0_bypass_a", a_val1, 8'hFF);
      chk8("r0_bypass_z", z_val1, 8'h00);
      step(1, 0, 3'd0, 8'h00, 1, 3'd0, 3'd0, 3'd7);
      chk8("r0_read_a", a_val1, 8'hFF);
      chk1("r0_busy_a", a_busy1, 1'b1);
      chk8("r0_read_z", z_val1, 8'h00);
      chk1("r0_busy_z", z_busy1, 1'b0);
      chk8("r7_read_z", z_val2, 8'h12);
      chk1("r0_lt_z", z_lt, 1'b1);
      step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd0);
      chk1("r0_err_a", a_err, 1'b1);
      chk1("r0_err_z", z_err, 1'b0);
      chk1("r0_stall_z", z_stall, 1'b0);
      chk8("r0_final_z", z_val2, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per register.
REQ-002 SHALL have parameter DEPTH, default 8, meaning register count (power of two, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter R0_ZERO, default 0, meaning when 1 register 0 reads as zero and ignores writes and reservations.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 CLK  in  1  clock, all state updates on rising edge.
REQ-006 RSTn  in  1  synchronous active-low reset.
REQ-007 rd_addr1, rd_addr2  in  AW  read port addresses.
REQ-008 rd_val1, rd_val2  out  WIDTH  read data, bypassed.
REQ-009 cmp_eq  out  1  rd_val1 == rd_val2; cmp_lt  out  1  rd_val1 < rd_val2, unsigned.
REQ-010 wr_en  in  1 / wr_addr  in  AW / wr_data  in  WIDTH  write port (writeback).
REQ-011 rsv_en  in  1 / rsv_addr  in  AW  reserve register as pending (issued multi-cycle producer).
REQ-012 busy1, busy2  out  1  source register pending, value not yet valid.
REQ-013 stall  out  1  busy1 | busy2.
REQ-014 rsv_err  out  1  sticky: reservation hit an already-pending register.

Function
REQ-015 Reads SHALL be combinational; rd_valN = array[rd_addrN], except when wr_en=1 and wr_addr==rd_addrN the port SHALL return wr_data (same-cycle bypass).
REQ-016 With R0_ZERO=1, reads of address 0 SHALL return 0 regardless of bypass.
REQ-017 cmp_eq/cmp_lt SHALL be computed from bypassed rd_val1/rd_val2, same cycle, zero latency.
REQ-018 Write: wr_en=1 SHALL update array[wr_addr] at the next rising edge; one-cycle write latency, visible via bypass in the write cycle.
REQ-019 Pending bits pend[DEPTH]: rsv_en=1 SHALL set pend[rsv_addr]; wr_en=1 SHALL clear pend[wr_addr]; both on the next edge.
REQ-020 Simultaneous rsv_en and wr_en to the same address: set SHALL win (new producer supersedes writeback); the data write still occurs.
REQ-021 busyN = pend[rd_addrN] & ~(wr_en & wr_addr==rd_addrN); a writeback in the current cycle resolves the hazard via bypass.
REQ-022 busyN SHALL be 0 for address 0 when R0_ZERO=1; reservations and writes to address 0 are then ignored.
REQ-023 rsv_err SHALL set on the edge after rsv_en=1 to an address whose pend bit is 1 and which is not being written that cycle; it stays set until reset.
REQ-024 stall SHALL be purely combinational from busy1/busy2; the block does not hold any input itself.

Reset
REQ-025 On a rising CLK edge with RSTn=0: all registers SHALL clear to 0, all pend bits to 0, rsv_err to 0; wr_en and rsv_en that cycle SHALL be ignored.
REQ-026 During and after reset: rd_val1=rd_val2=0 (absent bypass), cmp_eq=1, cmp_lt=0, busy1=busy2=stall=0, rsv_err=0.
REQ-027 Reset mid-reservation SHALL drop all pending state; a later writeback to a previously reserved register is an ordinary write.

Structure
REQ-028 Default WIDTH/DEPTH constants and the log2 address-width helper SHALL live in shared package rf_pkg.
REQ-029 One sub-module rf_read_port (address decode, bypass mux, R0 zeroing, busy) SHALL be instantiated once per read port.
REQ-030 Storage array and pend vector SHALL be flops (no RAM macro) to support reset and combinational reads.

Verification
REQ-031 Reset, then read r3/r5 -> rd_val1=rd_val2=0, cmp_eq=1, cmp_lt=0, stall=0.
REQ-032 Write r2=0x5A; same cycle read rd_addr1=2 -> rd_val1=0x5A (bypass); next cycle without write -> still 0x5A.
REQ-033 r1=0x10, r4=0x20; read 1,4 -> cmp_eq=0, cmp_lt=1; swap ports -> cmp_lt=0.
REQ-034 rsv r6; next cycle read 6 -> busy1=1, stall=1; cycle with wr r6=0x77 -> busy1=0, rd_val1=0x77; following cycle pend clear.
REQ-035 rsv r6 and wr r6 same cycle -> next cycle busy=1; rsv r6 again without write -> rsv_err=1 next cycle, held until RSTn=0.
REQ-036 R0_ZERO=1: wr r0=0xFF, rsv r0 -> rd r0=0, busy=0, rsv_err=0; R0_ZERO=0: same stimulus -> rd r0=0xFF.
